// File: rtl/joint_encoder.sv
// ---------------------------------------------------------------------------
// joint_encoder
// Quadrature encoder feedback stage for one closed-loop joint. Synchronises
// and glitch-filters the encoder lines, decodes A/B at 4x resolution into a
// signed position count, captures the position at an armed index edge, flags
// illegal (double-bit) transitions and measures velocity as the count delta
// over a fixed window.
//
// Ports
//   clk             system clock (sysclk domain)
//   rst             synchronous active-high reset
//   ENC_A/B/Z       raw asynchronous encoder channels and index
//   index_arm       level; while high the next filtered Z rise captures position
//   error_clr       one-cycle pulse clearing quad_error
//   jointFeedback   signed 32-bit position count
//   jointVelocity   signed count delta over the last completed window
//   index_position  position captured at the index edge
//   index_valid     sticky capture flag, cleared when index_arm rises
//   quad_error      sticky illegal-transition flag
// ---------------------------------------------------------------------------
module joint_encoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned VEL_WINDOW = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ENC_A,
    input  logic        ENC_B,
    input  logic        ENC_Z,
    input  logic        index_arm,
    input  logic        error_clr,
    output logic [31:0] jointFeedback,
    output logic [31:0] jointVelocity,
    output logic [31:0] index_position,
    output logic        index_valid,
    output logic        quad_error
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMR_W   = $clog2(VEL_WINDOW);
    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned CH_A    = 2;
    localparam int unsigned CH_B    = 1;
    localparam int unsigned CH_Z    = 0;
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(VEL_WINDOW - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        state_q;
    state_t        state_nxt;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] filt_c;

    logic [1:0]    filt_ab_c;
    logic [1:0]    prev_ab_q;
    logic [1:0]    pos_diff_c;
    logic          inc_c;
    logic          dec_c;
    logic          illegal_c;

    logic [31:0]   fb_q;
    logic [31:0]   fb_next_c;

    logic          z_prev_q;
    logic          arm_prev_q;
    logic          z_rise_c;
    logic          arm_rise_c;
    logic          capture_c;

    logic [TMR_W-1:0] tmr_q;
    logic [31:0]      snap_q;

    // Position of an {A,B} pair along the forward sequence 00->10->11->01.
    function automatic logic [1:0] ab_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Two-flop synchroniser on A, B and Z.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {ENC_A, ENC_B, ENC_Z};
            sync2_q <= sync1_q;
        end
    end

    // Per-channel stability filter. The filtered level is deliberately not
    // reset: it mirrors the physical line, so a reset while the encoder rests
    // off 00 does not fabricate an edge once the synchroniser refills.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_filt
        logic [CNT_W-1:0] cnt_q;
        logic             filt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if ((sync2_q[i] == filt_q) || (cnt_q == FILT_LAST)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst && (sync2_q[i] != filt_q) && (cnt_q == FILT_LAST)) begin
                filt_q <= sync2_q[i];
            end
        end

        assign filt_c[i] = filt_q;
    end

    assign filt_ab_c = {filt_c[CH_A], filt_c[CH_B]};

    // Init/run sequencing register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and quadrature step decode; nothing counts during init.
    always_comb begin
        state_nxt  = state_q;
        inc_c      = 1'b0;
        dec_c      = 1'b0;
        illegal_c  = 1'b0;
        pos_diff_c = ab_pos(filt_ab_c) - ab_pos(prev_ab_q);
        unique case (state_q)
            ST_INIT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                case (pos_diff_c)
                    2'd1:    inc_c     = 1'b1;
                    2'd3:    dec_c     = 1'b1;
                    2'd2:    illegal_c = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    // Count update with two's complement wrap.
    always_comb begin
        fb_next_c = fb_q;
        if (inc_c) begin
            fb_next_c = fb_q + 32'd1;
        end else if (dec_c) begin
            fb_next_c = fb_q - 32'd1;
        end
    end

    // Previous A/B sample: loaded during init, tracked every cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab_q <= '0;
        end else begin
            prev_ab_q <= filt_ab_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q <= '0;
        end else begin
            fb_q <= fb_next_c;
        end
    end

    assign jointFeedback = fb_q;

    // Illegal transition beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            quad_error <= 1'b0;
        end else if (illegal_c) begin
            quad_error <= 1'b1;
        end else if (error_clr) begin
            quad_error <= 1'b0;
        end
    end

    // Edge detectors for filtered Z and index_arm; Z edges are ignored until
    // the previous-Z register has been seeded during init.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_prev_q   <= 1'b0;
            arm_prev_q <= 1'b0;
        end else begin
            z_prev_q   <= filt_c[CH_Z];
            arm_prev_q <= index_arm;
        end
    end

    assign z_rise_c   = filt_c[CH_Z] & ~z_prev_q & (state_q == ST_RUN);
    assign arm_rise_c = index_arm & ~arm_prev_q;
    // A re-arm in the same cycle as a Z edge counts as already cleared.
    assign capture_c  = z_rise_c & index_arm & (~index_valid | arm_rise_c);

    // Index capture takes the post-update count of the edge cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_position <= '0;
            index_valid    <= 1'b0;
        end else if (capture_c) begin
            index_position <= fb_next_c;
            index_valid    <= 1'b1;
        end else if (arm_rise_c) begin
            index_valid    <= 1'b0;
        end
    end

    // Windowed velocity: delta of the count between successive terminal counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q         <= '0;
            snap_q        <= '0;
            jointVelocity <= '0;
        end else if (tmr_q == TMR_LAST) begin
            tmr_q         <= '0;
            snap_q        <= fb_next_c;
            jointVelocity <= fb_next_c - snap_q;
        end else begin
            tmr_q         <= tmr_q + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_joint_encoder.sv
// ---------------------------------------------------------------------------
// tb_joint_encoder
// Self-checking bench for joint_encoder. Encoder motion is commanded as
// forward/reverse steps along the quadrature cycle; the expected position is
// the signed sum of commanded steps, velocity is steps per window.
// ---------------------------------------------------------------------------
module tb_joint_encoder;

    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned VEL_WIN     = 1000;
    localparam int          STEP_PERIOD = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        ENC_A;
    logic        ENC_B;
    logic        ENC_Z;
    logic        index_arm;
    logic        error_clr;
    logic [31:0] jointFeedback;
    logic [31:0] jointVelocity;
    logic [31:0] index_position;
    logic        index_valid;
    logic        quad_error;

    int          n_checks = 0;
    int          n_fails  = 0;

    // Reference model: commanded quadrature phase and accumulated position.
    logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int          phase   = 0;
    logic [31:0] model_pos = '0;
    logic [31:0] exp_idx   = '0;

    joint_encoder #(
        .FILTER_LEN (FILTER_LEN),
        .VEL_WINDOW (VEL_WIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ENC_A          (ENC_A),
        .ENC_B          (ENC_B),
        .ENC_Z          (ENC_Z),
        .index_arm      (index_arm),
        .error_clr      (error_clr),
        .jointFeedback  (jointFeedback),
        .jointVelocity  (jointVelocity),
        .index_position (index_position),
        .index_valid    (index_valid),
        .quad_error     (quad_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_ab();
        {ENC_A, ENC_B} = seq[phase];
    endtask

    task automatic step(input int dir, input int hold);
        phase     = (phase + dir) & 3;
        model_pos = model_pos + 32'(dir);
        drive_ab();
        repeat (hold) @(negedge clk);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pos = '0;
    endtask

    // Short pulse on A or B that must never reach the filtered level.
    task automatic glitch(input bit on_a, input int len);
        if (on_a) ENC_A = ~ENC_A;
        else      ENC_B = ~ENC_B;
        repeat (len) @(negedge clk);
        drive_ab();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb"},  jointFeedback, 32'd0);
        check({tag, "_vel"}, jointVelocity, 32'd0);
        check({tag, "_ipos"}, index_position, 32'd0);
        check({tag, "_ival"}, 32'(index_valid), 32'd0);
        check({tag, "_err"}, 32'(quad_error), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ENC_A = 1'b0; ENC_B = 1'b0; ENC_Z = 1'b0;
        index_arm = 1'b0; error_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        // Let the unreset filtered levels settle onto idle inputs, then restart.
        repeat (20) @(negedge clk);
        reset_dut();
        settle();
        check("idle_fb", jointFeedback, 32'd0);

        // Forward steps; first change lands on the 7th sampling edge.
        phase = 1; model_pos = 32'd1; drive_ab();
        repeat (6) @(negedge clk);
        check("lat_before", jointFeedback, 32'd0);
        @(negedge clk);
        check("lat_at", jointFeedback, 32'd1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) step(1, 10);
        settle();
        check("fwd8", jointFeedback, 32'd8);
        check("fwd8_model", jointFeedback, model_pos);
        check("fwd8_err", 32'(quad_error), 32'd0);

        // Reverse from zero, including the wrap to -1.
        reset_dut();
        step(-1, 10);
        settle();
        check("wrap_neg", jointFeedback, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) step(-1, 10);
        settle();
        check("rev8", jointFeedback, 32'hFFFF_FFF8);
        check("rev8_model", jointFeedback, model_pos);

        // Positive wrap from the largest count.
        @(negedge clk);
        force dut.fb_q = 32'h7FFF_FFFF;
        @(negedge clk);
        release dut.fb_q;
        model_pos = 32'h7FFF_FFFF;
        check("force_hold", jointFeedback, 32'h7FFF_FFFF);
        step(1, 10);
        check("wrap_pos", jointFeedback, 32'h8000_0000);
        check("wrap_pos_model", jointFeedback, model_pos);

        // Glitch rejection, illegal jump, clear, clear coincident with error.
        reset_dut();
        settle();
        glitch(1'b1, int'(FILTER_LEN) - 1);
        check("glitch_fb", jointFeedback, model_pos);
        check("glitch_err", 32'(quad_error), 32'd0);
        phase = (phase + 2) & 3; drive_ab();
        settle();
        check("illegal_err", 32'(quad_error), 32'd1);
        check("illegal_fb", jointFeedback, model_pos);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 32'(quad_error), 32'd0);
        phase = (phase + 2) & 3; drive_ab();
        repeat (6) @(negedge clk);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        check("err_wins", 32'(quad_error), 32'd1);
        settle();
        check("err_wins_fb", jointFeedback, model_pos);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;

        // Random walk with occasional sub-filter glitches.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 1) == 1) ? 1 : -1, int'($urandom_range(6, 12)));
            if ($urandom_range(0, 3) == 0)
                glitch($urandom_range(0, 1) == 1, int'($urandom_range(1, FILTER_LEN - 1)));
            if ((i % 40) == 39) begin
                settle();
                check("rand_fb", jointFeedback, model_pos);
                check("rand_err", 32'(quad_error), 32'd0);
            end
        end

        // Index capture at position 100 + 3 steps.
        reset_dut();
        for (int i = 0; i < 100; i++) step(1, 8);
        index_arm = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            ENC_Z = (i == 3) || (i == 5);
            if (i == 3) exp_idx = model_pos + 32'd1;
            step(1, 10);
            ENC_Z = 1'b0;
        end
        settle();
        check("idx_valid", 32'(index_valid), 32'd1);
        check("idx_pos", index_position, exp_idx);
        check("idx_pos103", index_position, 32'd103);
        check("idx_fb", jointFeedback, model_pos);
        index_arm = 1'b0;
        repeat (2) @(negedge clk);
        index_arm = 1'b1;
        repeat (2) @(negedge clk);
        check("idx_rearm", 32'(index_valid), 32'd0);

        // Velocity at one step per STEP_PERIOD, then reversed.
        reset_dut();
        for (int i = 0; i < 60; i++) step(1, STEP_PERIOD);
        check("vel_fwd", jointVelocity, 32'(int'(VEL_WIN) / STEP_PERIOD));
        for (int i = 0; i < 60; i++) step(-1, STEP_PERIOD);
        check("vel_rev", jointVelocity, 32'(-(int'(VEL_WIN) / STEP_PERIOD)));
        settle();
        check("vel_fb", jointFeedback, model_pos);

        // Reset mid-filter and mid-window while resting at 11 with an error set.
        phase = (phase + 2) & 3; drive_ab();
        settle();
        check("pre_rst_err", 32'(quad_error), 32'd1);
        while (phase != 2) step(1, 10);
        settle();
        ENC_A = 1'b0;
        repeat (2) @(negedge clk);
        ENC_A = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pos = '0;
        check("midrst_fb", jointFeedback, 32'd0);
        check("midrst_vel", jointVelocity, 32'd0);
        check("midrst_ival", 32'(index_valid), 32'd0);
        check("midrst_err", 32'(quad_error), 32'd0);
        repeat (30) @(negedge clk);
        check("rest11_fb", jointFeedback, 32'd0);
        check("rest11_err", 32'(quad_error), 32'd0);
        repeat (1100) @(negedge clk);
        check("rest11_vel", jointVelocity, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
